// File: rtl/otter_pipe_pkg.sv
// otter_pipe_pkg: opcode/branch/pc-source types, the per-stage control bundle and hazard helpers
package otter_pipe_pkg;
  typedef enum logic [6:0] {
    OP_LUI    = 7'b0110111,
    OP_AUIPC  = 7'b0010111,
    OP_JAL    = 7'b1101111,
    OP_JALR   = 7'b1100111,
    OP_BRANCH = 7'b1100011,
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_IMM    = 7'b0010011,
    OP_REG    = 7'b0110011,
    OP_SYSTEM = 7'b1110011
  } opcode_t;
  typedef enum logic [2:0] {
    F3_BEQ  = 3'b000,
    F3_BNE  = 3'b001,
    F3_BLT  = 3'b100,
    F3_BGE  = 3'b101,
    F3_BLTU = 3'b110,
    F3_BGEU = 3'b111
  } func3_br_t;
  typedef enum logic [2:0] {
    PC_PLUS4  = 3'd0,
    PC_JAL    = 3'd1,
    PC_BRANCH = 3'd2,
    PC_JALR   = 3'd3,
    PC_MTVEC  = 3'd4,
    PC_MEPC   = 3'd5
  } pcsrc_t;
  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       uses_rs1;
    logic       uses_rs2;
    logic       alu_srca;
    logic [1:0] alu_srcb;
    logic [3:0] alu_func;
    logic       mem_read;
    logic       mem_write;
    logic       mem_sign;
    logic [1:0] mem_size;
    logic       reg_wr;
    logic       csr_write;
    logic [1:0] rf_wr_sel;
    logic       br;
    func3_br_t  br_type;
    pcsrc_t     jmp;
  } ctrl_t;
  localparam ctrl_t CTRL_NOP = '0;
  // a writer with rd=x0 never creates a dependency
  function automatic logic hits(logic [4:0] rd, logic [4:0] rs1, logic u1, logic [4:0] rs2, logic u2);
    return rd != 5'd0 && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
  endfunction
  // younger producer (MEM) wins over older one (WB)
  function automatic logic [1:0] fwd_sel(logic [4:0] rs, logic used, logic [4:0] mem_rd, logic [4:0] wb_rd);
    return (!used || rs == 5'd0) ? 2'd0 : mem_rd == rs ? 2'd1 : wb_rd == rs ? 2'd2 : 2'd0;
  endfunction
endpackage

// File: rtl/otter_pipe_ctrl_if.sv
// otter_pipe_ctrl_if: decode/comparator/memory inputs and per-stage control outputs of the pipeline control unit
//   master: datapath side (drives instruction, flags, mem_ready; receives control)
//   slave : control unit side
interface otter_pipe_ctrl_if;
  logic [31:0] dec_ir;
  logic        dec_valid;
  logic        br_eq;
  logic        br_lt;
  logic        br_ltu;
  logic        int_taken;
  logic        mem_ready;
  logic [2:0]  pc_source;
  logic        stall_f;
  logic        stall_d;
  logic        flush_d;
  logic        alu_srca;
  logic [1:0]  alu_srcb;
  logic [3:0]  alu_func;
  logic [1:0]  fwd_a;
  logic [1:0]  fwd_b;
  logic        mem_read2;
  logic        mem_write2;
  logic        mem_sign;
  logic [1:0]  mem_size;
  logic        reg_wr_en;
  logic        csr_write;
  logic [1:0]  rf_wr_sel;
  modport master (
    output dec_ir, dec_valid, br_eq, br_lt, br_ltu, int_taken, mem_ready,
    input  pc_source, stall_f, stall_d, flush_d, alu_srca, alu_srcb, alu_func, fwd_a, fwd_b,
           mem_read2, mem_write2, mem_sign, mem_size, reg_wr_en, csr_write, rf_wr_sel
  );
  modport slave (
    input  dec_ir, dec_valid, br_eq, br_lt, br_ltu, int_taken, mem_ready,
    output pc_source, stall_f, stall_d, flush_d, alu_srca, alu_srcb, alu_func, fwd_a, fwd_b,
           mem_read2, mem_write2, mem_sign, mem_size, reg_wr_en, csr_write, rf_wr_sel
  );
endinterface

// File: rtl/otter_ctrl_decode.sv
// otter_ctrl_decode: combinational decode of the DEC instruction into a control bundle
//   ir/valid in, ctrl out; invalid slots and unknown opcodes decode to no-op bundles
module otter_ctrl_decode import otter_pipe_pkg::*; #(
  parameter bit MRET_EN = 1'b1
) (
  input  logic [31:0] ir,
  input  logic        valid,
  output ctrl_t       ctrl
);
  opcode_t op;
  logic [2:0] f3;
  logic unused_ir;
  assign op = opcode_t'(ir[6:0]);
  assign f3 = ir[14:12];
  assign unused_ir = ^{ir[31], ir[29:25]};
  always_comb begin
    ctrl = CTRL_NOP;
    ctrl.valid = 1'b1;
    ctrl.rs1 = ir[19:15];
    ctrl.rs2 = ir[24:20];
    ctrl.br_type = func3_br_t'(f3);
    case (op)
      OP_REG: begin
        ctrl.reg_wr = 1'b1;
        ctrl.rf_wr_sel = 2'd3;
        ctrl.uses_rs1 = 1'b1;
        ctrl.uses_rs2 = 1'b1;
        ctrl.alu_func = {ir[30], f3};
      end
      OP_IMM: begin
        ctrl.reg_wr = 1'b1;
        ctrl.rf_wr_sel = 2'd3;
        ctrl.uses_rs1 = 1'b1;
        ctrl.alu_srcb = 2'd1;
        // only srai carries the function bit in the immediate
        ctrl.alu_func = {f3 == 3'b101 && ir[30], f3};
      end
      OP_LUI: begin
        ctrl.reg_wr = 1'b1;
        ctrl.rf_wr_sel = 2'd3;
        ctrl.alu_srca = 1'b1;
        ctrl.alu_func = 4'b1001;
      end
      OP_AUIPC: begin
        ctrl.reg_wr = 1'b1;
        ctrl.rf_wr_sel = 2'd3;
        ctrl.alu_srca = 1'b1;
        ctrl.alu_srcb = 2'd3;
      end
      OP_JAL: begin
        ctrl.reg_wr = 1'b1;
        ctrl.jmp = PC_JAL;
      end
      OP_JALR: begin
        ctrl.reg_wr = 1'b1;
        ctrl.uses_rs1 = 1'b1;
        ctrl.jmp = PC_JALR;
      end
      OP_BRANCH: begin
        ctrl.br = 1'b1;
        ctrl.uses_rs1 = 1'b1;
        ctrl.uses_rs2 = 1'b1;
      end
      OP_LOAD: begin
        ctrl.reg_wr = 1'b1;
        ctrl.rf_wr_sel = 2'd2;
        ctrl.uses_rs1 = 1'b1;
        ctrl.alu_srcb = 2'd1;
        ctrl.mem_read = 1'b1;
        ctrl.mem_sign = ir[14];
        ctrl.mem_size = ir[13:12];
      end
      OP_STORE: begin
        ctrl.uses_rs1 = 1'b1;
        ctrl.uses_rs2 = 1'b1;
        ctrl.alu_srcb = 2'd2;
        ctrl.mem_write = 1'b1;
        ctrl.mem_sign = ir[14];
        ctrl.mem_size = ir[13:12];
      end
      OP_SYSTEM: begin
        if (f3 == 3'b001) begin
          ctrl.reg_wr = 1'b1;
          ctrl.csr_write = 1'b1;
          ctrl.rf_wr_sel = 2'd1;
          ctrl.uses_rs1 = 1'b1;
        end else if (f3 == 3'b000 && MRET_EN) begin
          ctrl.jmp = PC_MEPC;
        end
      end
      default: ;
    endcase
    ctrl.rd = ctrl.reg_wr ? ir[11:7] : 5'd0;
    if (!valid) ctrl = CTRL_NOP;
  end
endmodule

// File: rtl/otter_pipe_ctrl.sv
// otter_pipe_ctrl: 5-stage OTTER control unit with stage registers, hazards, forwarding and redirects
//   clk/rst: clock and asynchronous active-high reset; bus: slave side of otter_pipe_ctrl_if
module otter_pipe_ctrl import otter_pipe_pkg::*; #(
  parameter bit FWD_EN  = 1'b1,
  parameter bit INT_EN  = 1'b1,
  parameter bit MRET_EN = 1'b1
) (
  input logic clk,
  input logic rst,
  otter_pipe_ctrl_if.slave bus
);
  ctrl_t dec, ex, mem, wb;
  pcsrc_t src;
  logic taken, redirect, hazard, hz_stall, unused_stage;
  otter_ctrl_decode #(.MRET_EN(MRET_EN)) u_decode (
    .ir(bus.dec_ir),
    .valid(bus.dec_valid),
    .ctrl(dec)
  );
  always_comb begin
    taken = ex.br && (ex.br_type == F3_BEQ  ?  bus.br_eq  :
                      ex.br_type == F3_BNE  ? !bus.br_eq  :
                      ex.br_type == F3_BLT  ?  bus.br_lt  :
                      ex.br_type == F3_BGE  ? !bus.br_lt  :
                      ex.br_type == F3_BLTU ?  bus.br_ltu :
                      ex.br_type == F3_BGEU ? !bus.br_ltu : 1'b0);
    src = !ex.valid ? PC_PLUS4 :
          (INT_EN && bus.int_taken) ? PC_MTVEC :
          ex.jmp != PC_PLUS4 ? ex.jmp :
          taken ? PC_BRANCH : PC_PLUS4;
    // a frozen pipeline holds its redirect until memory is ready again
    redirect = bus.mem_ready && src != PC_PLUS4;
    hazard = FWD_EN ? ex.mem_read && hits(ex.rd, dec.rs1, dec.uses_rs1, dec.rs2, dec.uses_rs2) :
             hits(ex.rd, dec.rs1, dec.uses_rs1, dec.rs2, dec.uses_rs2) ||
             hits(mem.rd, dec.rs1, dec.uses_rs1, dec.rs2, dec.uses_rs2) ||
             hits(wb.rd, dec.rs1, dec.uses_rs1, dec.rs2, dec.uses_rs2);
    // the DEC instruction is being flushed anyway, so its stall is moot
    hz_stall = hazard && !redirect;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ex <= CTRL_NOP;
      mem <= CTRL_NOP;
      wb <= CTRL_NOP;
    end else if (bus.mem_ready) begin
      ex <= (redirect || hz_stall) ? CTRL_NOP : dec;
      mem <= ex;
      wb <= mem;
    end
  assign bus.pc_source = redirect ? src : PC_PLUS4;
  assign bus.stall_f = !rst && (!bus.mem_ready || hz_stall);
  assign bus.stall_d = bus.stall_f;
  assign bus.flush_d = redirect;
  assign bus.alu_srca = ex.alu_srca;
  assign bus.alu_srcb = ex.alu_srcb;
  assign bus.alu_func = ex.alu_func;
  assign bus.fwd_a = FWD_EN ? fwd_sel(ex.rs1, ex.uses_rs1, mem.rd, wb.rd) : 2'd0;
  assign bus.fwd_b = FWD_EN ? fwd_sel(ex.rs2, ex.uses_rs2, mem.rd, wb.rd) : 2'd0;
  assign bus.mem_read2 = mem.mem_read;
  assign bus.mem_write2 = mem.mem_write;
  assign bus.mem_sign = mem.mem_sign;
  assign bus.mem_size = mem.mem_size;
  assign bus.reg_wr_en = wb.reg_wr;
  assign bus.csr_write = wb.csr_write;
  assign bus.rf_wr_sel = wb.rf_wr_sel;
  assign unused_stage = ^{ex, mem, wb};
endmodule

// File: tb/tb_otter_pipe_ctrl.sv
// tb_otter_pipe_ctrl: randomized instruction stream against a stage-by-stage reference model for three parameter sets
module tb_otter_pipe_ctrl;
  typedef struct packed {
    logic       valid;
    logic [3:0] kind;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic       srca;
    logic [1:0] srcb;
    logic [3:0] func;
    logic       mrd;
    logic       mwr;
    logic       msign;
    logic [1:0] msize;
    logic       rwe;
    logic       csrw;
    logic [1:0] sel;
    logic [2:0] f3;
  } ins_t;
  localparam ins_t NOP_I = '0;
  localparam int K_R = 1, K_I = 2, K_LUI = 3, K_AUIPC = 4, K_JAL = 5, K_JALR = 6, K_BR = 7,
                 K_LD = 8, K_ST = 9, K_MRET = 10, K_CSR = 11, K_UNK = 12;
  localparam bit FE [3] = '{1'b1, 1'b0, 1'b1};
  localparam bit IE [3] = '{1'b1, 1'b1, 1'b0};
  localparam bit ME [3] = '{1'b1, 1'b1, 1'b0};
  logic clk, rst, dec_valid, br_eq, br_lt, br_ltu, int_taken, mem_ready;
  logic [31:0] dec_ir;
  logic [25:0] obs [3];
  logic [25:0] expw [3];
  ins_t cur;
  ins_t mex [3];
  ins_t mmem [3];
  ins_t mwb [3];
  logic m_redir [3];
  logic m_hz [3];
  int errors, checks, cyc;
  for (genvar g = 0; g < 3; g++) begin : u
    otter_pipe_ctrl_if bus ();
    assign bus.dec_ir = dec_ir;
    assign bus.dec_valid = dec_valid;
    assign bus.br_eq = br_eq;
    assign bus.br_lt = br_lt;
    assign bus.br_ltu = br_ltu;
    assign bus.int_taken = int_taken;
    assign bus.mem_ready = mem_ready;
    otter_pipe_ctrl #(.FWD_EN(g != 1), .INT_EN(g != 2), .MRET_EN(g != 2)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
    );
    assign obs[g] = {bus.pc_source, bus.stall_f, bus.stall_d, bus.flush_d, bus.alu_srca, bus.alu_srcb,
                     bus.alu_func, bus.fwd_a, bus.fwd_b, bus.mem_read2, bus.mem_write2, bus.mem_sign,
                     bus.mem_size, bus.reg_wr_en, bus.csr_write, bus.rf_wr_sel};
  end
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask
  // builds an encoding from the intended instruction and records what it should do
  task automatic make(input int k, output logic [31:0] ir, output ins_t x);
    logic [31:0] r;
    logic [4:0] rd, rs1, rs2;
    logic [2:0] f3;
    logic b30;
    r = $urandom;
    rd = 5'($urandom_range(0, 3));
    rs1 = 5'($urandom_range(0, 3));
    rs2 = 5'($urandom_range(0, 3));
    f3 = 3'($urandom);
    b30 = r[0];
    x = '0;
    x.valid = 1'b1;
    x.kind = 4'(k);
    x.rs1 = rs1;
    x.rs2 = rs2;
    case (k)
      K_R: begin
        b30 = (f3 == 3'd0 || f3 == 3'd5) && r[0];
        ir = {1'b0, b30, 5'd0, rs2, rs1, f3, rd, 7'b0110011};
        x.u1 = 1; x.u2 = 1; x.func = {b30, f3}; x.rwe = 1; x.sel = 3; x.rd = rd;
      end
      K_I: begin
        ir = {(f3 == 3'd1 || f3 == 3'd5) ? {1'b0, b30, 5'd0} : {r[31], b30, r[29:25]}, rs2, rs1, f3, rd, 7'b0010011};
        x.u1 = 1; x.srcb = 1; x.func = {f3 == 3'd5 ? b30 : 1'b0, f3}; x.rwe = 1; x.sel = 3; x.rd = rd;
      end
      K_LUI: begin
        ir = {r[31:12], rd, 7'b0110111};
        x.srca = 1; x.func = 4'b1001; x.rwe = 1; x.sel = 3; x.rd = rd;
      end
      K_AUIPC: begin
        ir = {r[31:12], rd, 7'b0010111};
        x.srca = 1; x.srcb = 3; x.rwe = 1; x.sel = 3; x.rd = rd;
      end
      K_JAL: begin
        ir = {r[31:12], rd, 7'b1101111};
        x.rwe = 1; x.rd = rd;
      end
      K_JALR: begin
        ir = {r[31:20], rs1, 3'b000, rd, 7'b1100111};
        x.u1 = 1; x.rwe = 1; x.rd = rd;
      end
      K_BR: begin
        ir = {r[31:25], rs2, rs1, f3, r[11:7], 7'b1100011};
        x.u1 = 1; x.u2 = 1; x.f3 = f3;
      end
      K_LD: begin
        f3 = 3'($urandom_range(0, 4));
        f3 = f3 > 3'd2 ? f3 + 3'd1 : f3;
        ir = {r[31:20], rs1, f3, rd, 7'b0000011};
        x.u1 = 1; x.srcb = 1; x.mrd = 1; x.msign = f3[2]; x.msize = f3[1:0]; x.rwe = 1; x.sel = 2; x.rd = rd;
      end
      K_ST: begin
        f3 = 3'($urandom_range(0, 2));
        ir = {r[31:25], rs2, rs1, f3, r[11:7], 7'b0100011};
        x.u1 = 1; x.u2 = 1; x.srcb = 2; x.mwr = 1; x.msize = f3[1:0];
      end
      K_MRET: ir = 32'h30200073;
      K_CSR: begin
        ir = {r[31:20], rs1, 3'b001, rd, 7'b1110011};
        x.u1 = 1; x.rwe = 1; x.csrw = 1; x.sel = 1; x.rd = rd;
      end
      default: ir = {r[31:7], 7'b0001011};
    endcase
  endtask
  function automatic bit dep(ins_t w, ins_t d);
    return w.rd != 5'd0 && ((d.u1 && d.rs1 == w.rd) || (d.u2 && d.rs2 == w.rd));
  endfunction
  function automatic bit br_taken(logic [2:0] f3, logic eq, logic lt, logic ltu);
    case (f3)
      3'd0: return eq;
      3'd1: return !eq;
      3'd4: return lt;
      3'd5: return !lt;
      3'd6: return ltu;
      3'd7: return !ltu;
      default: return 1'b0;
    endcase
  endfunction
  function automatic logic [1:0] src_of(logic [4:0] rs, logic used, ins_t m, ins_t w);
    if (!used || rs == 5'd0) return 2'd0;
    if (m.rd == rs) return 2'd1;
    if (w.rd == rs) return 2'd2;
    return 2'd0;
  endfunction
  task automatic eval(input int c);
    ins_t e, d;
    logic [2:0] pc;
    logic hz, st;
    logic [1:0] fa, fb;
    e = mex[c];
    d = dec_valid ? cur : NOP_I;
    pc = 3'd0;
    if (e.valid) begin
      if (int_taken && IE[c]) pc = 3'd4;
      else if (e.kind == K_JAL) pc = 3'd1;
      else if (e.kind == K_JALR) pc = 3'd3;
      else if (e.kind == K_MRET && ME[c]) pc = 3'd5;
      else if (e.kind == K_BR && br_taken(e.f3, br_eq, br_lt, br_ltu)) pc = 3'd2;
    end
    m_redir[c] = mem_ready && pc != 3'd0;
    hz = FE[c] ? (e.mrd && dep(e, d)) : (dep(e, d) || dep(mmem[c], d) || dep(mwb[c], d));
    m_hz[c] = hz && !m_redir[c];
    st = !rst && (!mem_ready || m_hz[c]);
    fa = FE[c] ? src_of(e.rs1, e.u1, mmem[c], mwb[c]) : 2'd0;
    fb = FE[c] ? src_of(e.rs2, e.u2, mmem[c], mwb[c]) : 2'd0;
    expw[c] = {m_redir[c] ? pc : 3'd0, st, st, m_redir[c], e.srca, e.srcb, e.func, fa, fb,
               mmem[c].mrd, mmem[c].mwr, mmem[c].msign, mmem[c].msize, mwb[c].rwe, mwb[c].csrw, mwb[c].sel};
  endtask
  task automatic step(input int c);
    if (rst) begin
      mex[c] = NOP_I; mmem[c] = NOP_I; mwb[c] = NOP_I;
    end else if (mem_ready) begin
      mwb[c] = mmem[c];
      mmem[c] = mex[c];
      mex[c] = (m_redir[c] || m_hz[c] || !dec_valid) ? NOP_I : cur;
    end
  endtask
  initial begin
    errors = 0;
    checks = 0;
    cyc = 0;
    rst = 1'b1;
    br_eq = 0; br_lt = 0; br_ltu = 0; int_taken = 0; mem_ready = 1;
    dec_valid = 1'b0;
    make(K_R, dec_ir, cur);
    for (int n = 0; n < 3000; n++) begin
      cyc = n;
      rst = n < 3 || (n >= 1500 && n < 1503);
      if (rst) for (int c = 0; c < 3; c++) begin
        mex[c] = NOP_I; mmem[c] = NOP_I; mwb[c] = NOP_I;
      end
      @(negedge clk);
      for (int c = 0; c < 3; c++) begin
        eval(c);
        chk($sformatf("c%0d pc_source", c), 32'(obs[c][25:23]), 32'(expw[c][25:23]));
        chk($sformatf("c%0d stall_flush", c), 32'(obs[c][22:20]), 32'(expw[c][22:20]));
        chk($sformatf("c%0d exe_alu", c), 32'(obs[c][19:13]), 32'(expw[c][19:13]));
        chk($sformatf("c%0d fwd", c), 32'(obs[c][12:9]), 32'(expw[c][12:9]));
        chk($sformatf("c%0d mem", c), 32'(obs[c][8:4]), 32'(expw[c][8:4]));
        chk($sformatf("c%0d wb", c), 32'(obs[c][3:0]), 32'(expw[c][3:0]));
      end
      @(posedge clk);
      for (int c = 0; c < 3; c++) step(c);
      #1;
      br_eq = 1'($urandom);
      br_lt = 1'($urandom);
      br_ltu = 1'($urandom);
      int_taken = $urandom_range(0, 15) == 0;
      mem_ready = $urandom_range(0, 7) != 0;
      if (!expw[0][22] || rst) begin
        make($urandom_range(K_R, K_UNK), dec_ir, cur);
        dec_valid = !m_redir[0] && $urandom_range(0, 9) != 0;
      end
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
